// File: rtl/udp_rx_layer_pkg.sv
// rtl/udp_rx_layer_pkg.sv - shared types and constants for the UDP receive layer
package udp_rx_layer_pkg;

    localparam logic [7:0] UDP_PROTOCOL = 8'h11;
    localparam int         UDP_HDR_LEN  = 8;

    // Byte-stream beat shared by the IPv4 and UDP RX paths.
    typedef struct packed {
        logic [7:0] data_in;
        logic       data_in_valid;
        logic       data_in_last;
    } axi_in_type;

    typedef struct packed {
        logic data_in_ready;
    } axi_out_type;

    typedef struct packed {
        logic        is_valid;
        logic [7:0]  protocol;
        logic [15:0] data_length;
        logic [31:0] src_ip_addr;
    } ipv4_rx_header_type;

    typedef struct packed {
        ipv4_rx_header_type hdr;
        axi_in_type         data;
    } ipv4_rx_type;

    typedef struct packed {
        logic        is_valid;
        logic [31:0] src_ip_addr;
        logic [15:0] src_port;
        logic [15:0] dst_port;
        logic [15:0] data_length;
    } udp_rx_header_type;

    typedef struct packed {
        udp_rx_header_type hdr;
        axi_in_type        data;
    } udp_rx_type;

    typedef enum logic [2:0] {
        UDPRX_IDLE,
        UDPRX_HDR,
        UDPRX_PAYLOAD,
        UDPRX_TAIL,
        UDPRX_SKIP
    } udp_rx_state_type;

    // A UDP length field is usable only if it covers the header and fits the IP payload.
    function automatic logic udp_len_ok(input logic [15:0] udp_len, input logic [15:0] ip_len);
        return (udp_len >= 16'(UDP_HDR_LEN)) && (udp_len <= ip_len);
    endfunction

endpackage

// File: rtl/udp_rx_layer_if.sv
// rtl/udp_rx_layer_if.sv - IPv4 RX input and UDP RX output bundle of the UDP receive layer
import udp_rx_layer_pkg::*;

interface udp_rx_layer_if;
    logic        ip_rx_start;
    ipv4_rx_type ip_rx;
    logic        udp_rx_start;
    udp_rx_type  udp_rxo;

    // master: the side feeding the IP stream and consuming the UDP stream
    modport master (
        output ip_rx_start,
        output ip_rx,
        input  udp_rx_start,
        input  udp_rxo
    );

    modport slave (
        input  ip_rx_start,
        input  ip_rx,
        output udp_rx_start,
        output udp_rxo
    );
endinterface

// File: rtl/udp_rx_layer.sv
// rtl/udp_rx_layer.sv - strips and filters the UDP header, forwards payload with one cycle latency
module udp_rx_layer
    import udp_rx_layer_pkg::*;
#(
    parameter bit          PORT_FILTER_EN = 1'b0,
    parameter logic [15:0] LOCAL_PORT     = 16'd0,
    parameter int          DROP_CNT_W     = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    udp_rx_layer_if.slave         bus,
    output logic [DROP_CNT_W-1:0] udp_drop_cnt
);

    udp_rx_state_type      state_q;
    logic [2:0]            hdr_cnt_q;
    logic [15:0]           pay_cnt_q;
    logic [15:0]           src_port_q;
    logic [15:0]           dst_port_q;
    logic [15:0]           udp_len_q;
    logic [DROP_CNT_W-1:0] drop_cnt_q;
    logic                  start_q;
    udp_rx_header_type     rxo_hdr_q;
    axi_in_type            rxo_data_q;

    logic                  ip_start;
    logic                  in_valid;
    logic                  in_last;
    logic [7:0]            in_byte;
    logic                  start_is_udp;
    logic                  hdr_drop;
    logic                  abort_counts;
    logic                  pay_final;
    logic [15:0]           pay_len_d;
    logic [DROP_CNT_W-1:0] drop_cnt_d;

    assign ip_start     = bus.ip_rx_start;
    assign in_valid     = bus.ip_rx.data.data_in_valid;
    assign in_last      = bus.ip_rx.data.data_in_last;
    assign in_byte      = bus.ip_rx.data.data_in;
    assign start_is_udp = bus.ip_rx.hdr.is_valid && (bus.ip_rx.hdr.protocol == UDP_PROTOCOL);

    // Evaluated on the cycle of header byte 7; all checked fields are already captured.
    assign hdr_drop     = !udp_len_ok(udp_len_q, bus.ip_rx.hdr.data_length)
                        || (PORT_FILTER_EN && (dst_port_q != LOCAL_PORT));
    assign pay_len_d    = udp_len_q - 16'(UDP_HDR_LEN);
    assign abort_counts = (state_q == UDPRX_HDR) || (state_q == UDPRX_PAYLOAD);
    assign pay_final    = (pay_cnt_q == rxo_hdr_q.data_length - 16'd1);
    assign drop_cnt_d   = (&drop_cnt_q) ? drop_cnt_q : drop_cnt_q + DROP_CNT_W'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= UDPRX_IDLE;
            hdr_cnt_q  <= '0;
            pay_cnt_q  <= '0;
            src_port_q <= '0;
            dst_port_q <= '0;
            udp_len_q  <= '0;
            drop_cnt_q <= '0;
            start_q    <= 1'b0;
            rxo_hdr_q  <= '0;
            rxo_data_q <= '0;
        end else begin
            start_q    <= 1'b0;
            rxo_data_q <= '0;

            if (ip_start) begin
                // A start from any state aborts the current frame and is decoded as a fresh one.
                if (abort_counts) begin
                    drop_cnt_q <= drop_cnt_d;
                end
                rxo_hdr_q.is_valid <= 1'b0;
                hdr_cnt_q          <= '0;
                state_q            <= start_is_udp ? UDPRX_HDR : UDPRX_SKIP;
            end else if (in_valid) begin
                unique case (state_q)
                    UDPRX_HDR: begin
                        hdr_cnt_q <= hdr_cnt_q + 3'd1;
                        case (hdr_cnt_q)
                            3'd0:    src_port_q[15:8] <= in_byte;
                            3'd1:    src_port_q[7:0]  <= in_byte;
                            3'd2:    dst_port_q[15:8] <= in_byte;
                            3'd3:    dst_port_q[7:0]  <= in_byte;
                            3'd4:    udp_len_q[15:8]  <= in_byte;
                            3'd5:    udp_len_q[7:0]   <= in_byte;
                            default: ;
                        endcase
                        if (hdr_cnt_q == 3'd7) begin
                            if (hdr_drop) begin
                                drop_cnt_q <= drop_cnt_d;
                                state_q    <= in_last ? UDPRX_IDLE : UDPRX_SKIP;
                            end else begin
                                start_q               <= 1'b1;
                                rxo_hdr_q.is_valid    <= 1'b1;
                                rxo_hdr_q.src_ip_addr <= bus.ip_rx.hdr.src_ip_addr;
                                rxo_hdr_q.src_port    <= src_port_q;
                                rxo_hdr_q.dst_port    <= dst_port_q;
                                rxo_hdr_q.data_length <= pay_len_d;
                                pay_cnt_q             <= '0;
                                if (in_last) begin
                                    // IP frame ended with the header: any promised payload is missing.
                                    if (pay_len_d != 16'd0) begin
                                        drop_cnt_q <= drop_cnt_d;
                                    end
                                    state_q <= UDPRX_IDLE;
                                end else begin
                                    state_q <= (pay_len_d == 16'd0) ? UDPRX_TAIL : UDPRX_PAYLOAD;
                                end
                            end
                        end else if (in_last) begin
                            drop_cnt_q <= drop_cnt_d;
                            state_q    <= UDPRX_IDLE;
                        end
                    end
                    UDPRX_PAYLOAD: begin
                        rxo_data_q.data_in       <= in_byte;
                        rxo_data_q.data_in_valid <= 1'b1;
                        pay_cnt_q                <= pay_cnt_q + 16'd1;
                        if (pay_final) begin
                            rxo_data_q.data_in_last <= 1'b1;
                            state_q                 <= in_last ? UDPRX_IDLE : UDPRX_TAIL;
                        end else if (in_last) begin
                            rxo_data_q.data_in_last <= 1'b1;
                            drop_cnt_q              <= drop_cnt_d;
                            state_q                 <= UDPRX_IDLE;
                        end
                    end
                    UDPRX_TAIL, UDPRX_SKIP: begin
                        if (in_last) begin
                            state_q <= UDPRX_IDLE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.udp_rx_start = start_q;
    assign bus.udp_rxo.hdr  = rxo_hdr_q;
    assign bus.udp_rxo.data = rxo_data_q;
    assign udp_drop_cnt     = drop_cnt_q;

endmodule

// File: tb/tb_udp_rx_layer.sv
// tb/tb_udp_rx_layer.sv - self-checking bench for udp_rx_layer against a frame-level model
`timescale 1ns/1ps
module tb_udp_rx_layer;
    import udp_rx_layer_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        drv_start = 1'b0;
    ipv4_rx_type drv_ip = '0;
    logic [7:0]  cnt_a;
    logic [2:0]  cnt_b;

    udp_rx_layer_if ifa();
    udp_rx_layer_if ifb();

    assign ifa.ip_rx_start = drv_start;
    assign ifa.ip_rx       = drv_ip;
    assign ifb.ip_rx_start = drv_start;
    assign ifb.ip_rx       = drv_ip;

    udp_rx_layer #(.PORT_FILTER_EN(1'b0), .LOCAL_PORT(16'd0), .DROP_CNT_W(8)) dut_a (
        .clk(clk), .reset_n(reset_n), .bus(ifa), .udp_drop_cnt(cnt_a));
    udp_rx_layer #(.PORT_FILTER_EN(1'b1), .LOCAL_PORT(16'h5678), .DROP_CNT_W(3)) dut_b (
        .clk(clk), .reset_n(reset_n), .bus(ifb), .udp_drop_cnt(cnt_b));

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h @%0t", nm, act, exp, $time);
        end
    endtask

    // Frame-level model: byte index within the frame decides header/payload/trailer.
    int                cmax[2] = '{255, 7};
    bit                filt[2] = '{1'b0, 1'b1};
    bit                m_active, m_udp;
    int                m_k, m_dl;
    logic [15:0]       m_iplen;
    logic [31:0]       m_srcip;
    logic [7:0]        m_hb[8];
    bit                m_pass[2];
    int                m_cnt[2];
    udp_rx_header_type m_hdr[2];
    bit                nx_start[2], nx_valid[2], nx_last[2];
    logic [7:0]        nx_data[2];
    bit                exp_start[2], exp_valid[2], exp_last[2];
    logic [7:0]        exp_data[2];
    int                exp_cnt[2];
    udp_rx_header_type exp_hdr[2];

    task automatic bump(input int d);
        if (m_cnt[d] < cmax[d]) m_cnt[d]++;
    endtask

    task automatic model_clear();
        m_active = 1'b0; m_udp = 1'b0; m_k = 0; m_dl = 0;
        for (int d = 0; d < 2; d++) begin
            m_pass[d] = 1'b0; m_cnt[d] = 0; m_hdr[d] = '0;
            nx_start[d] = 1'b0; nx_valid[d] = 1'b0; nx_last[d] = 1'b0; nx_data[d] = '0;
            exp_start[d] = 1'b0; exp_valid[d] = 1'b0; exp_last[d] = 1'b0; exp_data[d] = '0;
            exp_cnt[d] = 0; exp_hdr[d] = '0;
        end
    endtask

    task automatic model_step(input bit st, input bit v, input logic [7:0] b, input bit l);
        int idx, p;
        logic [15:0] len, sp, dp;
        for (int d = 0; d < 2; d++) begin
            nx_start[d] = 1'b0; nx_valid[d] = 1'b0; nx_last[d] = 1'b0; nx_data[d] = '0;
        end
        if (st) begin
            for (int d = 0; d < 2; d++) begin
                if (m_active && m_udp && (m_k < 8 || (m_pass[d] && (m_k - 8) < m_dl))) bump(d);
                m_hdr[d].is_valid = 1'b0;
                m_pass[d] = 1'b0;
            end
            m_active = 1'b1;
            m_udp    = drv_ip.hdr.is_valid && drv_ip.hdr.protocol == 8'd17;
            m_k      = 0;
            m_iplen  = drv_ip.hdr.data_length;
            m_srcip  = drv_ip.hdr.src_ip_addr;
        end else if (m_active && v) begin
            if (!m_udp) begin
                if (l) m_active = 1'b0;
            end else begin
                idx = m_k;
                m_k++;
                if (idx < 7) begin
                    m_hb[idx] = b;
                    if (l) begin bump(0); bump(1); m_active = 1'b0; end
                end else if (idx == 7) begin
                    sp   = {m_hb[0], m_hb[1]};
                    dp   = {m_hb[2], m_hb[3]};
                    len  = {m_hb[4], m_hb[5]};
                    m_dl = int'(len) - 8;
                    for (int d = 0; d < 2; d++) begin
                        if (len < 16'd8 || len > m_iplen || (filt[d] && dp != 16'h5678)) begin
                            bump(d);
                            m_pass[d] = 1'b0;
                        end else begin
                            m_pass[d]   = 1'b1;
                            nx_start[d] = 1'b1;
                            m_hdr[d]    = '{is_valid: 1'b1, src_ip_addr: m_srcip, src_port: sp,
                                            dst_port: dp, data_length: len - 16'd8};
                            if (l && m_dl > 0) bump(d);
                        end
                    end
                    if (l) m_active = 1'b0;
                end else begin
                    p = idx - 8;
                    for (int d = 0; d < 2; d++) begin
                        if (m_pass[d] && p < m_dl) begin
                            nx_valid[d] = 1'b1;
                            nx_data[d]  = b;
                            nx_last[d]  = (p == m_dl - 1) || l;
                            if (l && p < m_dl - 1) bump(d);
                        end
                    end
                    if (l) m_active = 1'b0;
                end
            end
        end
    endtask

    task automatic step(input bit st, input bit v, input logic [7:0] b, input bit l);
        drv_start = st;
        drv_ip.data.data_in       = b;
        drv_ip.data.data_in_valid = v;
        drv_ip.data.data_in_last  = l;
        model_step(st, v, b, l);
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            exp_start[d] = nx_start[d]; exp_valid[d] = nx_valid[d];
            exp_last[d]  = nx_last[d];  exp_data[d]  = nx_data[d];
            exp_cnt[d]   = m_cnt[d];    exp_hdr[d]   = m_hdr[d];
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'($urandom), 1'b0);
    endtask

    // Observation of DUT A only, for the hand-computed expectations.
    logic [7:0] ob_bytes[$];
    int ob_starts = 0;
    int ob_lasts  = 0;

    task automatic cmp(input int d, input logic st, input udp_rx_type o, input logic [7:0] c);
        chk($sformatf("d%0d_start", d), 128'(st), 128'(exp_start[d]));
        chk($sformatf("d%0d_valid", d), 128'(o.data.data_in_valid), 128'(exp_valid[d]));
        chk($sformatf("d%0d_last", d), 128'(o.data.data_in_last), 128'(exp_last[d]));
        chk($sformatf("d%0d_hdr", d), 128'(o.hdr), 128'(exp_hdr[d]));
        chk($sformatf("d%0d_cnt", d), 128'(c), 128'(exp_cnt[d]));
        if (exp_valid[d]) chk($sformatf("d%0d_data", d), 128'(o.data.data_in), 128'(exp_data[d]));
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp(0, ifa.udp_rx_start, ifa.udp_rxo, cnt_a);
            cmp(1, ifb.udp_rx_start, ifb.udp_rxo, {5'd0, cnt_b});
            if (ifa.udp_rx_start) ob_starts++;
            if (ifa.udp_rxo.data.data_in_valid) ob_bytes.push_back(ifa.udp_rxo.data.data_in);
            if (ifa.udp_rxo.data.data_in_last) ob_lasts++;
        end
    end

    task automatic clear_obs();
        ob_bytes.delete();
        ob_starts = 0;
        ob_lasts  = 0;
    endtask

    task automatic do_reset();
        drv_start = 1'b0;
        drv_ip    = '0;
        reset_n   = 1'b0;
        model_clear();
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        clear_obs();
    endtask

    logic [7:0] fb[$];

    task automatic build(input logic [15:0] sp, input logic [15:0] dp, input logic [15:0] ulen,
                         input int total);
        fb.delete();
        fb.push_back(sp[15:8]); fb.push_back(sp[7:0]);
        fb.push_back(dp[15:8]); fb.push_back(dp[7:0]);
        fb.push_back(ulen[15:8]); fb.push_back(ulen[7:0]);
        while (fb.size() < total) fb.push_back(8'($urandom));
    endtask

    task automatic send_frame(input bit hv, input logic [7:0] proto, input logic [15:0] iplen,
                              input logic [31:0] sip, input int nsend, input bit with_last,
                              input int gap_pct, input int idle_after);
        drv_ip.hdr = '{is_valid: hv, protocol: proto, data_length: iplen, src_ip_addr: sip};
        step(1'b1, 1'b0, 8'($urandom), 1'b0);
        for (int i = 0; i < nsend; i++) begin
            while (int'($urandom_range(99)) < gap_pct) step(1'b0, 1'b0, 8'($urandom), 1'b0);
            step(1'b0, 1'b1, fb[i], with_last && (i == nsend - 1));
        end
        idle(idle_after);
    endtask

    initial begin
        logic [15:0] iplen, ulen, dp;
        int total, nsend, mode;
        bit wl;

        model_clear();
        chk_en = 1'b1;
        do_reset();
        chk("rst_start", 128'(ifa.udp_rx_start), 128'd0);
        chk("rst_rxo", 128'(ifa.udp_rxo), 128'd0);
        chk("rst_cnt", 128'(cnt_a), 128'd0);

        // Nominal datagram
        build(16'h1234, 16'h5678, 16'h000C, 12);
        fb[6] = 8'h00; fb[7] = 8'h00;
        fb[8] = 8'hAA; fb[9] = 8'hBB; fb[10] = 8'hCC; fb[11] = 8'hDD;
        send_frame(1'b1, 8'd17, 16'd12, 32'hC0A80001, 12, 1'b1, 0, 2);
        chk("t1_starts", 128'(ob_starts), 128'd1);
        chk("t1_nbytes", 128'(ob_bytes.size()), 128'd4);
        if (ob_bytes.size() == 4)
            chk("t1_bytes", 128'({ob_bytes[0], ob_bytes[1], ob_bytes[2], ob_bytes[3]}), 128'hAABBCCDD);
        chk("t1_lasts", 128'(ob_lasts), 128'd1);
        chk("t1_sport", 128'(ifa.udp_rxo.hdr.src_port), 128'h1234);
        chk("t1_dport", 128'(ifa.udp_rxo.hdr.dst_port), 128'h5678);
        chk("t1_dlen", 128'(ifa.udp_rxo.hdr.data_length), 128'd4);
        chk("t1_sip", 128'(ifa.udp_rxo.hdr.src_ip_addr), 128'hC0A80001);
        chk("t1_cnt", 128'(cnt_a), 128'd0);

        // Non-UDP
        clear_obs();
        build(16'h1111, 16'h5678, 16'h0014, 20);
        send_frame(1'b1, 8'd6, 16'd20, 32'h0A000001, 20, 1'b1, 10, 2);
        chk("t2_starts", 128'(ob_starts), 128'd0);
        chk("t2_nbytes", 128'(ob_bytes.size()), 128'd0);
        chk("t2_cnt", 128'(cnt_a), 128'd0);

        // Bad length: too short, then longer than the IP payload
        do_reset();
        build(16'h1111, 16'h5678, 16'h0004, 20);
        send_frame(1'b1, 8'd17, 16'd20, 32'h0A000001, 20, 1'b1, 0, 1);
        build(16'h1111, 16'h5678, 16'h0040, 20);
        send_frame(1'b1, 8'd17, 16'd20, 32'h0A000001, 20, 1'b1, 0, 1);
        chk("t3_starts", 128'(ob_starts), 128'd0);
        chk("t3_cnt", 128'(cnt_a), 128'd2);

        // Zero payload with padding, then a 2-byte payload with padding
        do_reset();
        build(16'h2222, 16'h5678, 16'h0008, 10);
        send_frame(1'b1, 8'd17, 16'd18, 32'h0A000002, 10, 1'b1, 0, 1);
        chk("t4_starts0", 128'(ob_starts), 128'd1);
        chk("t4_dlen0", 128'(ifa.udp_rxo.hdr.data_length), 128'd0);
        chk("t4_nbytes0", 128'(ob_bytes.size()), 128'd0);
        build(16'h2222, 16'h5678, 16'h000A, 12);
        send_frame(1'b1, 8'd17, 16'd20, 32'h0A000002, 12, 1'b1, 0, 1);
        chk("t4_nbytes1", 128'(ob_bytes.size()), 128'd2);
        chk("t4_lasts1", 128'(ob_lasts), 128'd1);
        chk("t4_cnt", 128'(cnt_a), 128'd0);

        // Truncated payload, then abort mid-payload, then a clean frame
        do_reset();
        build(16'h3333, 16'h5678, 16'h000C, 12);
        send_frame(1'b1, 8'd17, 16'd12, 32'h0A000003, 10, 1'b1, 0, 1);
        chk("t5_nbytes", 128'(ob_bytes.size()), 128'd2);
        chk("t5_lasts", 128'(ob_lasts), 128'd1);
        chk("t5_cnt1", 128'(cnt_a), 128'd1);
        clear_obs();
        send_frame(1'b1, 8'd17, 16'd12, 32'h0A000003, 9, 1'b0, 0, 0);
        build(16'h4444, 16'h5678, 16'h000B, 11);
        send_frame(1'b1, 8'd17, 16'd11, 32'h0A000004, 11, 1'b1, 0, 1);
        chk("t5_cnt2", 128'(cnt_a), 128'd2);
        chk("t5_lasts2", 128'(ob_lasts), 128'd1);
        chk("t5_nbytes2", 128'(ob_bytes.size()), 128'd4);
        chk("t5_sport", 128'(ifa.udp_rxo.hdr.src_port), 128'h4444);

        // Port filter and asynchronous reset mid-payload
        do_reset();
        build(16'h5555, 16'h9999, 16'h000C, 12);
        send_frame(1'b1, 8'd17, 16'd12, 32'h0A000005, 12, 1'b1, 0, 1);
        chk("t6_cnt_b", 128'(cnt_b), 128'd1);
        chk("t6_cnt_a", 128'(cnt_a), 128'd0);
        build(16'h6666, 16'h5678, 16'h0010, 16);
        send_frame(1'b1, 8'd17, 16'd16, 32'h0A000006, 10, 1'b0, 0, 0);
        chk("t6_pre_valid", 128'(ifa.udp_rxo.data.data_in_valid), 128'd1);
        #2;
        reset_n = 1'b0;
        model_clear();
        #1;
        chk("t6_rst_rxo", 128'(ifa.udp_rxo), 128'd0);
        chk("t6_rst_start", 128'(ifa.udp_rx_start), 128'd0);
        chk("t6_rst_cnt_b", 128'(cnt_b), 128'd0);
        drv_start = 1'b0;
        drv_ip    = '0;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        clear_obs();
        build(16'h7777, 16'h5678, 16'h000A, 10);
        send_frame(1'b1, 8'd17, 16'd10, 32'h0A000007, 10, 1'b1, 0, 1);
        chk("t6_post_starts", 128'(ob_starts), 128'd1);
        chk("t6_post_nbytes", 128'(ob_bytes.size()), 128'd2);

        // Saturation of the 3-bit counter
        do_reset();
        for (int i = 0; i < 10; i++) begin
            build(16'h8888, 16'h5678, 16'h0003, 8);
            send_frame(1'b1, 8'd17, 16'd8, 32'h0A000008, 8, 1'b1, 0, 0);
        end
        idle(1);
        chk("t7_cnt_b_sat", 128'(cnt_b), 128'd7);
        chk("t7_cnt_a", 128'(cnt_a), 128'd10);

        // Randomized traffic
        do_reset();
        for (int f = 0; f < 200; f++) begin
            iplen = 16'(8 + $urandom_range(23));
            case ($urandom_range(5))
                0:       ulen = 16'($urandom_range(7));
                1:       ulen = iplen + 16'(1 + $urandom_range(9));
                default: ulen = 16'(8 + $urandom_range(int'(iplen) - 8));
            endcase
            dp    = ($urandom_range(2) != 0) ? 16'h5678 : 16'($urandom);
            total = int'(iplen);
            build(16'($urandom), dp, ulen, total);
            mode = int'($urandom_range(9));
            if (mode == 0) begin
                nsend = 1 + int'($urandom_range(total - 1));
                wl    = 1'b1;
            end else if (mode == 1) begin
                nsend = int'($urandom_range(total));
                wl    = 1'b0;
            end else begin
                nsend = total;
                wl    = 1'b1;
            end
            send_frame($urandom_range(9) != 0, ($urandom_range(5) == 0) ? 8'd6 : 8'd17,
                       iplen, $urandom, nsend, wl, 20, wl ? int'($urandom_range(2)) : 0);
        end
        build(16'h9A9A, 16'h5678, 16'h000C, 12);
        send_frame(1'b1, 8'd17, 16'd12, 32'h0A000009, 12, 1'b1, 10, 3);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
